// File: rtl/regfile_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_sb_pkg
//
// Shared constants and types for the register file with write-pending
// scoreboard (regfile_sb and its rf_scoreboard sub-block).
//
// Contents:
//   DEF_DATA_W / DEF_ADDR_W  default register width / address width
//   ZERO_WORD                all-zero register value
//   reg_addr_t / reg_word_t  RegAddrBus / RegBus at the default widths
//   WRITE_ENABLE             level of an asserted write enable
//   READ_ENABLE              level of an asserted read enable
//   RST_ACTIVE               level of rst that holds the block in reset
//   rst_active()             helper: is the reset input asserted?
//
// Optional feature macro used by the top: XCORE_RF_DBG_EN.
// ---------------------------------------------------------------------------
package regfile_sb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_word_t;

  localparam reg_word_t ZERO_WORD    = '0;
  localparam logic      WRITE_ENABLE = 1'b1;
  localparam logic      READ_ENABLE  = 1'b1;
  localparam logic      RST_ACTIVE   = 1'b0;

  // True while the (active-low) reset input is asserted.
  function automatic logic rst_active(input logic rst_lvl);
    return (rst_lvl == RST_ACTIVE);
  endfunction

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
//
// Write-pending scoreboard for regfile_sb. Holds one busy bit per register,
// decides whether a destination reservation can be accepted, applies flush
// and keeps a registered count of reserved registers.
//
// Ports:
//   clk        clock, state updates on rising edge
//   rst        asynchronous active-low reset
//   clr        per-register "written this cycle" strobes (bit 0 never set)
//   iss_valid  reservation request
//   iss_rd     destination register to reserve
//   flush      synchronous clear of all reservations
//   busy       current busy vector (registered)
//   iss_ready  reservation accepted this cycle (combinational)
//   busy_cnt   registered popcount of busy
// ---------------------------------------------------------------------------
module rf_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2**ADDR_W-1:0]   clr,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_rd,
  input  logic                   flush,
  output logic [2**ADDR_W-1:0]   busy,
  output logic                   iss_ready,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_hit;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     cnt_d;
  logic [ADDR_W:0]     clr_cnt;
  logic                iss_fire;

  // A reservation is possible when the target is free, or when the only
  // thing keeping it busy is being retired by a write in this same cycle.
  always_comb begin
    iss_ready = 1'b0;
    if (!rst_active(rst) && !flush) begin
      iss_ready = (iss_rd == '0) || !busy_q[iss_rd] || clr[iss_rd];
    end
  end

  // r0 is accepted but never tracked.
  assign iss_fire = iss_valid & iss_ready & (iss_rd != '0);

  always_comb begin
    set_vec = '0;
    if (iss_fire) begin
      set_vec[iss_rd] = 1'b1;
    end
  end

  // Only bits that were actually busy reduce the count; a write to a free
  // register leaves the count alone.
  assign clr_hit = busy_q & clr;

  always_comb begin
    clr_cnt = '0;
    for (int a = 0; a < NUM_REGS; a++) begin
      clr_cnt = clr_cnt + {{ADDR_W{1'b0}}, clr_hit[a]};
    end
  end

  // Clear first, then set, so a same-cycle clear and set leaves the bit set.
  // In that case the bit was busy, so the +1/-1 cancel and the count holds.
  always_comb begin
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      busy_d = (busy_q & ~clr) | set_vec;
      cnt_d  = cnt_q + {{ADDR_W{1'b0}}, iss_fire} - clr_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule : rf_scoreboard

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//
// Multi-port integer register file with an integrated write-pending
// scoreboard. NUM_RD combinational read ports with same-cycle write bypass,
// NUM_WR write ports (highest port index wins on an address collision),
// register 0 hardwired to zero.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        asynchronous active-low reset
//   we         write enable per write port
//   waddr      packed write addresses, port i at [i*ADDR_W +: ADDR_W]
//   wdata      packed write data, port i at [i*DATA_W +: DATA_W]
//   re         read enable per read port
//   raddr      packed read addresses
//   rdata      packed read data (combinational)
//   rbusy      per read port: operand reserved and not yet written
//   iss_valid  destination reservation request
//   iss_rd     destination register to reserve
//   iss_ready  reservation accepted this cycle (combinational)
//   flush      synchronous clear of all reservations
//   busy_cnt   registered count of reserved registers
//
// Optional (macro XCORE_RF_DBG_EN defined):
//   dbg_addr   debug read address
//   dbg_rdata  registered debug read data (pre-write storage, no bypass)
//   dbg_busy   registered busy bit of dbg_addr
// ---------------------------------------------------------------------------
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_rd,
  output logic                       iss_ready,
  input  logic                       flush,
  output logic [ADDR_W:0]            busy_cnt
`ifdef XCORE_RF_DBG_EN
  ,
  input  logic [ADDR_W-1:0]          dbg_addr,
  output logic [DATA_W-1:0]          dbg_rdata,
  output logic                       dbg_busy
`endif
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   regs_q    [NUM_REGS];
  logic [NUM_REGS-1:0] reg_wen;
  logic [DATA_W-1:0]   reg_wdata [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;
  logic                rst_ok;

  assign rst_ok = !rst_active(rst);

  // -------------------------------------------------------------------------
  // Write-port arbitration, resolved per destination register. Scanning the
  // ports in ascending order lets the highest matching port overwrite the
  // earlier ones. r0 never sees a write strobe, so writes to it neither
  // change storage nor retire a reservation.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_wsel
      if (gi == 0) begin : g_zero
        assign reg_wen[gi]   = 1'b0;
        assign reg_wdata[gi] = '0;
      end else begin : g_reg
        logic              hit;
        logic [DATA_W-1:0] dat;
        always_comb begin
          hit = 1'b0;
          dat = '0;
          for (int i = 0; i < NUM_WR; i++) begin
            if (we[i] == WRITE_ENABLE &&
                waddr[i*ADDR_W +: ADDR_W] == ADDR_W'(gi)) begin
              hit = 1'b1;
              dat = wdata[i*DATA_W +: DATA_W];
            end
          end
        end
        assign reg_wen[gi]   = hit;
        assign reg_wdata[gi] = dat;
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Storage. Reset clears every entry; r0 is only ever loaded by reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < NUM_REGS; a++) begin
        regs_q[a] <= '0;
      end
    end else begin
      for (int a = 1; a < NUM_REGS; a++) begin
        if (reg_wen[a]) begin
          regs_q[a] <= reg_wdata[a];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .clr       (reg_wen),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .busy      (busy_vec),
    .iss_ready (iss_ready),
    .busy_cnt  (busy_cnt)
  );

  // -------------------------------------------------------------------------
  // Read ports. The arbitrated per-register write strobe doubles as the
  // bypass detector: it already encodes "highest port writing this address".
  // A bypassed operand is delivered now, so it is never reported busy.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      logic [DATA_W-1:0] rd_word;
      logic              rd_busy;
      logic              byp_hit;

      assign rd_addr = raddr[gi*ADDR_W +: ADDR_W];
      assign byp_hit = reg_wen[rd_addr];

      always_comb begin
        rd_word = '0;
        rd_busy = 1'b0;
        if (rst_ok && re[gi] == READ_ENABLE && rd_addr != '0) begin
          rd_word = byp_hit ? reg_wdata[rd_addr] : regs_q[rd_addr];
          rd_busy = busy_vec[rd_addr] & ~byp_hit;
        end
      end

      assign rdata[gi*DATA_W +: DATA_W] = rd_word;
      assign rbusy[gi]                  = rd_busy;
    end
  endgenerate

`ifdef XCORE_RF_DBG_EN
  // -------------------------------------------------------------------------
  // Debug read: registered, samples storage and busy as they were before the
  // writes landing on the same edge.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              dbg_busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_rdata_q <= '0;
      dbg_busy_q  <= 1'b0;
    end else if (dbg_addr == '0) begin
      dbg_rdata_q <= '0;
      dbg_busy_q  <= 1'b0;
    end else begin
      dbg_rdata_q <= regs_q[dbg_addr];
      dbg_busy_q  <= busy_vec[dbg_addr];
    end
  end

  assign dbg_rdata = dbg_rdata_q;
  assign dbg_busy  = dbg_busy_q;
`endif

endmodule : regfile_sb
